// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the integer register-file write port between execute
// (port 0) and load (port 1) writeback. Optional forwarding ports under REGFILE_WR_BYPASS_EN.
module regfile_wr_arbiter #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  localparam int RDW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            freeze,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [RDW-1:0]  req0_rd,
  input  logic [XLEN-1:0] req0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [RDW-1:0]  req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic [NREG-2:0] en_x,
  output logic [XLEN-1:0] wr_data,
  output logic            wr_valid,
  output logic [RDW-1:0]  wr_rd
`ifdef REGFILE_WR_BYPASS_EN
  ,
  input  logic [RDW-1:0]  byp_rd,
  output logic            byp_hit,
  output logic [XLEN-1:0] byp_data
`endif
);

  logic            last_grant_r;
  logic            grant0_s;
  logic            grant1_s;
  logic            xfer_s;
  logic [RDW-1:0]  sel_rd_s;
  logic [XLEN-1:0] sel_data_s;
  logic [RDW-1:0]  wr_rd_r;
  logic [XLEN-1:0] wr_data_r;
  logic            wr_valid_r;

  // One-hot decode of a register index; x0 has no enable bit.
  function automatic logic [NREG-2:0] rd_to_en(input logic [RDW-1:0] rd);
    logic [NREG-2:0] en;
    for (int i = 1; i < NREG; i++) begin
      en[i-1] = (rd == RDW'(i));
    end
    return en;
  endfunction

  // Grant selection: the sole valid port wins, otherwise the port that did not win last.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst_n && !freeze) begin
      if (req0_valid && (!req1_valid || last_grant_r)) begin
        grant0_s = 1'b1;
      end else if (req1_valid) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Write-port mux for the granted request.
  always_comb begin
    sel_rd_s   = req0_rd;
    sel_data_s = req0_data;
    if (grant1_s) begin
      sel_rd_s   = req1_rd;
      sel_data_s = req1_data;
    end else begin
      sel_rd_s   = req0_rd;
      sel_data_s = req0_data;
    end
  end

  assign xfer_s     = grant0_s | grant1_s;
  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Output stage and round-robin pointer; rd=0 transfers update the pointer but never write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
      wr_rd_r      <= '0;
      wr_data_r    <= '0;
      wr_valid_r   <= 1'b0;
    end else if (xfer_s) begin
      last_grant_r <= grant1_s;
      wr_rd_r      <= sel_rd_s;
      wr_data_r    <= sel_data_s;
      wr_valid_r   <= (sel_rd_s != '0);
    end else begin
      wr_rd_r      <= '0;
      wr_valid_r   <= 1'b0;
    end
  end

  // Enables come only from the registered stage, so reset clears them without a clock.
  assign en_x     = wr_valid_r ? rd_to_en(wr_rd_r) : '0;
  assign wr_data  = wr_data_r;
  assign wr_valid = wr_valid_r;
  assign wr_rd    = wr_rd_r;

`ifdef REGFILE_WR_BYPASS_EN
  assign byp_hit  = wr_valid_r && (wr_rd_r == byp_rd) && (byp_rd != '0);
  assign byp_data = byp_hit ? wr_data_r : '0;
`endif

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single integer register-file write port (31 × 64-bit enabled flops, x1..x31, common write-data bus) between two writeback requesters: port 0 is execute writeback and port 1 is load/memory writeback.
- Round-robin grant with a valid/ready handshake.
- One registered output stage drives the one-hot per-register enables and the shared write-data bus.
- Sits between the writeback stages and the register file.

Parameters:
- XLEN, 64, data width of requests and of the write-data bus.
- NREG, 32, architectural register count; rd width = log2(NREG); enables cover x1..x(NREG-1).

Ports:
- clk  in  1  clock; all state is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- freeze  in  1  when 1, no new grants; the output stage still drains.
- req0_valid  in  1  port 0 has a write pending.
- req0_ready  out  1  port 0 granted this cycle.
- req0_rd  in  5  port 0 destination register.
- req0_data  in  XLEN  port 0 write data.
- req1_valid  in  1  port 1 has a write pending.
- req1_ready  out  1  port 1 granted this cycle.
- req1_rd  in  5  port 1 destination register.
- req1_data  in  XLEN  port 1 write data.
- en_x  out  NREG-1  one-hot write enables; bit i-1 enables x_i.
- wr_data  out  XLEN  shared register-file write data.
- wr_valid  out  1  output stage holds a write to a nonzero rd.
- wr_rd  out  5  rd of the write in the output stage (0 when idle).

Behaviour:
- Reset, asynchronous with rst_n=0:
  - en_x=0, wr_data=0, wr_valid=0, wr_rd=0.
  - last_grant=1, so port 0 has priority first.
  - req*_ready are combinational and are 0 during reset.
- Handshake:
  - reqN_ready is combinational from the valids, last_grant and freeze.
  - A transfer occurs when valid && ready.
  - Requesters hold rd and data stable until the transfer.
  - At most one ready is asserted per cycle.
  - No ready is asserted while freeze=1 or rst_n=0.
- Arbitration:
  - Only one valid: that port is granted.
  - Both valid: the port != last_grant is granted.
  - last_grant updates only on a transfer.
- Latency: a transfer in cycle N produces, in cycle N+1 only:
  - en_x one-hot at rd-1;
  - wr_data = granted data, wr_rd = rd, wr_valid = 1.
  - The register file captures the write at the end of cycle N+1.
  - With no transfer in cycle N: en_x=0, wr_valid=0, wr_rd=0, and wr_data holds its last value.
- Throughput: one write per cycle. The output stage never stalls, so it is always accepted.
- rd=0:
  - The request is handshaken normally and last_grant updates.
  - In cycle N+1, en_x=0, wr_valid=0 and wr_rd=0 (write discarded).
- Same rd from both ports in the same cycle:
  - Written in grant order on consecutive cycles; the later grant's data persists.
  - The arbiter does no merging.
- freeze:
  - Asserted in cycle N: no transfer in cycle N; a write granted in N-1 still appears in cycle N.
  - Deasserted: arbitration resumes the same cycle using the preserved last_grant.
- Reset mid-operation: an in-flight output-stage write is dropped immediately, with en_x forced to 0 asynchronously.
- en_x is never more than one-hot. Bits are derived from the registered rd, not from a decode of live inputs.

Optional Feature:
- Macro REGFILE_WR_BYPASS_EN.
- Defined: adds ports byp_rd (in, 5), byp_hit (out, 1) and byp_data (out, XLEN), all combinational.
  - byp_hit = wr_valid && wr_rd==byp_rd && byp_rd!=0.
  - byp_data = wr_data when byp_hit, else 0.
  - Lets read stages forward the write landing this cycle.
- Undefined: these ports are absent; no other behaviour changes.

Test Plan:
- Reset, then req0_valid=1, rd=5, data=0x1234 in cycle 1 -> req0_ready=1 in cycle 1; in cycle 2 en_x=0x10 (bit 4), wr_data=0x1234, wr_rd=5, wr_valid=1; in cycle 3 en_x=0.
- Both valid for 4 cycles, rd0=3, rd1=7, each with new data per transfer -> grants alternate port 0, 1, 0, 1; en_x alternates bit 2 and bit 6 on cycles 2–5.
- req1 rd=0, data=0xFFFF -> req1_ready=1; the next cycle has en_x=0 and wr_valid=0; last_grant=1, so the next contention grants port 0.
- Both valid with rd=9: port 0 data 0xA, port 1 data 0xB -> en_x bit 8 on two consecutive cycles with wr_data 0xA then 0xB; a model register x9 ends at 0xB.
- freeze=1 for 3 cycles with both valid -> no ready and en_x=0 throughout, except the drain of a grant made the cycle before freeze; on release, the port != last_grant is granted first.
- Assert rst_n=0 mid-cycle while wr_valid=1 -> en_x=0, wr_valid=0 and wr_rd=0 immediately, without waiting for a clock edge. With REGFILE_WR_BYPASS_EN: byp_rd=5 during a cycle-2 write to rd 5 -> byp_hit=1, byp_data=0x1234; byp_rd=0 -> byp_hit=0.
